mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
Memory-access stage that sits directly downstream of the EX/MEM pipeline register. It issues loads and stores to the data-memory bus through a request/grant/response handshake, stalls the pipeline while an access is outstanding, and aligns and extends load data. It also owns the MEM/WB register, which feeds the write-back stage.

Parameters:
TIMEOUT_CYC, 255, cycles an access may spend in WAIT_GNT+WAIT_RESP before it is aborted with bus_err; 8-bit counter.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset; all state clears while low
in_regWAddr  in  5  destination register from EX/MEM
in_regRData2  in  32  store data from EX/MEM
in_result  in  32  EX result; used as the byte address for memory ops
in_pc  in  32  PC from EX/MEM
mem_read  in  1  load
mem_write  in  1  store; mem_read and mem_write are never both high
mem_size  in  2  0=byte, 1=half, 2=word; 3 is treated as word
mem_unsigned  in  1  zero-extend loads (LBU/LHU)
flush  in  1  pipeline flush
dmem_req  out  1  bus request
dmem_we  out  1  1=write
dmem_addr  out  32  word-aligned address ({in_result[31:2],2'b00})
dmem_wdata  out  32  store data replicated across byte lanes
dmem_wstrb  out  4  byte enables
dmem_gnt  in  1  request accepted this cycle
dmem_rvalid  in  1  response/write-ack, one cycle
dmem_rdata  in  32  read data, valid with dmem_rvalid
mem_stall  out  1  hold upstream stages; inputs stay stable while high
misalign_err  out  1  registered 1-cycle pulse
bus_err  out  1  registered 1-cycle pulse on timeout
wb_regWAddr  out  5  MEM/WB register; 0 means no write
wb_result  out  32  MEM/WB result
wb_pc  out  32  MEM/WB PC

Behaviour:
- States: IDLE, WAIT_GNT, WAIT_RESP, DRAIN. Reset: IDLE; all wb_* outputs, error pulses and the counter are 0.
- access = (mem_read|mem_write) & ~misaligned & ~flush.
- misaligned = (size==1 & addr[0]) | (size>=2 & addr[1:0]!=0).
- dmem_req = access in IDLE, or state==WAIT_GNT. It is combinational; dmem_addr, dmem_we, dmem_wdata and dmem_wstrb are driven from the held inputs.
- Write strobes:
  - byte: 4'b0001<<addr[1:0]; wdata = {4{d[7:0]}}
  - half: 4'b0011<<addr[1:0]; wdata = {2{d[15:0]}}
  - word: 4'b1111
- Read requests drive wstrb=0.
- mem_stall = 1 when access in IDLE, in WAIT_GNT, in WAIT_RESP without dmem_rvalid, and in DRAIN. It is 0 in the cycle dmem_rvalid completes a WAIT_RESP access.
- IDLE + access: go to WAIT_RESP if dmem_gnt, else WAIT_GNT. Minimum memory-op latency is 2 cycles.
- WAIT_GNT: if flush, go to IDLE with no request next cycle and load a bubble into MEM/WB. Otherwise go to WAIT_RESP on dmem_gnt.
- WAIT_RESP:
  - On dmem_rvalid: load MEM/WB and go to IDLE.
  - If flush arrives without rvalid: go to DRAIN.
  - If flush and rvalid arrive together: the bubble wins, go to IDLE.
- DRAIN: wait for dmem_rvalid, discard it, load a bubble, go to IDLE. A stored write has already been committed and is not undone.
- Timeout counter: clears on entry to WAIT_GNT or WAIT_RESP and increments each cycle there. When it reaches TIMEOUT_CYC: bus_err pulses, MEM/WB gets regWAddr=0, result=0, pc=in_pc, mem_stall drops that cycle, state goes to IDLE. A stray rvalid arriving later in IDLE is ignored.
- Load extraction uses lane = addr[1:0]:
  - byte = rdata[8*lane+:8]
  - half = rdata[8*lane+:16]
  - Sign-extend unless mem_unsigned; word is passed through.
- MEM/WB update on each edge where mem_stall==0:
  - flush: all wb_* = 0.
  - misaligned mem op: wb_regWAddr=0, wb_pc=in_pc, wb_result=0, and misalign_err pulses; no bus request is made.
  - load: wb_result = extracted data.
  - store: wb_regWAddr=0, wb_result=in_result.
  - non-memory op: wb_result=in_result, wb_regWAddr=in_regWAddr, wb_pc=in_pc, with 1-cycle latency.
- While mem_stall==1, MEM/WB holds its value except when a bubble is loaded as described above.
- reset asserted mid-access: immediate return to IDLE with dmem_req low; any response from the bus is ignored afterwards.

Test Plan:
1. ALU op, in_result=0x1234, in_regWAddr=5, no mem op → next edge wb_result=0x1234, wb_regWAddr=5, mem_stall never high.
2. LB at addr 0x103, gnt immediate, rvalid next cycle with rdata=0x80FF_0000 → wb_result=0xFFFF_FF80; with mem_unsigned=1 → 0x80; stall high exactly 1 cycle.
3. SH at addr 0x102, data 0xABCD, gnt delayed 3 cycles → dmem_req held 4 cycles with wstrb=4'b1100, wdata=0xABCD_ABCD; wb_regWAddr=0 after the ack.
4. LW at addr 0x101 → no dmem_req, misalign_err pulses once, wb_regWAddr=0, no stall.
5. LW granted, flush asserted before rvalid, rvalid 2 cycles later → DRAIN, data discarded, wb_* all 0, stall released the cycle after rvalid.
6. TIMEOUT_CYC=4, LW granted, rvalid never comes → bus_err pulses 4 cycles after entering WAIT_RESP, stall drops, state IDLE; assert reset low mid-wait → dmem_req=0 immediately.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: memory stage issuing loads/stores over a req/gnt/rvalid bus and owning the MEM/WB register
module mem_access #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  in_regWAddr,
    input  logic [31:0] in_regRData2,
    input  logic [31:0] in_result,
    input  logic [31:0] in_pc,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic        flush,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        misalign_err,
    output logic        bus_err,
    output logic [4:0]  wb_regWAddr,
    output logic [31:0] wb_result,
    output logic [31:0] wb_pc
);
    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RESP, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q;
    logic [1:0]  lane;
    logic [15:0] lane_data;
    logic        mem_op, misaligned, access, waiting, timeout;
    logic        bubble, bus_err_d, misalign_d, wb_en;
    logic [31:0] load_data, wb_result_d, wb_pc_d;
    logic [4:0]  wb_regWAddr_d;

    assign lane       = in_result[1:0];
    assign mem_op     = mem_read | mem_write;
    assign misaligned = ((mem_size == 2'd1) && lane[0]) || (mem_size[1] && (lane != 2'd0));
    assign access     = mem_op & ~misaligned & ~flush;
    assign waiting    = (state_q == WAIT_GNT) || (state_q == WAIT_RESP);
    assign timeout    = waiting && (cnt_q == 8'(TIMEOUT_CYC - 1));

    assign lane_data  = 16'(dmem_rdata >> {lane, 3'b000});
    assign load_data  = (mem_size == 2'd0) ? {{24{~mem_unsigned & lane_data[7]}}, lane_data[7:0]} :
                        (mem_size == 2'd1) ? {{16{~mem_unsigned & lane_data[15]}}, lane_data} :
                        dmem_rdata;

    assign dmem_we    = mem_write;
    assign dmem_addr  = {in_result[31:2], 2'b00};
    assign dmem_wdata = (mem_size == 2'd0) ? {4{in_regRData2[7:0]}} :
                        (mem_size == 2'd1) ? {2{in_regRData2[15:0]}} :
                        in_regRData2;
    assign dmem_wstrb = !mem_write         ? 4'b0000 :
                        (mem_size == 2'd0) ? 4'b0001 << lane :
                        (mem_size == 2'd1) ? 4'b0011 << lane :
                        4'b1111;

    always_comb begin
        state_d   = state_q;
        dmem_req  = 1'b0;
        mem_stall = 1'b0;
        bus_err_d = 1'b0;
        bubble    = 1'b0;
        case (state_q)
            IDLE: begin
                dmem_req  = access;
                mem_stall = access;
                if (access) state_d = dmem_gnt ? WAIT_RESP : WAIT_GNT;
            end
            WAIT_GNT: begin
                dmem_req  = 1'b1;
                mem_stall = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                    bubble  = 1'b1;
                end else if (dmem_gnt) begin
                    state_d = WAIT_RESP;
                end else if (timeout) begin
                    state_d   = IDLE;
                    bus_err_d = 1'b1;
                    mem_stall = 1'b0;
                end
            end
            WAIT_RESP: begin
                mem_stall = 1'b1;
                if (dmem_rvalid) begin
                    state_d   = IDLE;
                    mem_stall = 1'b0;
                end else if (timeout) begin
                    state_d   = IDLE;
                    bus_err_d = 1'b1;
                    mem_stall = 1'b0;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                mem_stall = 1'b1;
                if (dmem_rvalid) begin
                    state_d = IDLE;
                    bubble  = 1'b1;
                end
            end
        endcase
        // An in-flight access must vanish from the bus as soon as reset is asserted
        if (!reset) begin
            dmem_req  = 1'b0;
            mem_stall = 1'b0;
        end
    end

    assign wb_en = ~mem_stall | bubble;

    always_comb begin
        wb_regWAddr_d = in_regWAddr;
        wb_result_d   = in_result;
        wb_pc_d       = in_pc;
        misalign_d    = 1'b0;
        if (bubble || flush) begin
            wb_regWAddr_d = 5'd0;
            wb_result_d   = 32'd0;
            wb_pc_d       = 32'd0;
        end else if (bus_err_d) begin
            wb_regWAddr_d = 5'd0;
            wb_result_d   = 32'd0;
        end else if (mem_op && misaligned) begin
            wb_regWAddr_d = 5'd0;
            wb_result_d   = 32'd0;
            misalign_d    = 1'b1;
        end else if (mem_read) begin
            wb_result_d   = load_data;
        end else if (mem_write) begin
            wb_regWAddr_d = 5'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            wb_regWAddr  <= 5'd0;
            wb_result    <= 32'd0;
            wb_pc        <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= (waiting && state_d == state_q) ? cnt_q + 8'd1 : 8'd0;
            misalign_err <= wb_en & misalign_d;
            bus_err      <= bus_err_d;
            if (wb_en) begin
                wb_regWAddr <= wb_regWAddr_d;
                wb_result   <= wb_result_d;
                wb_pc       <= wb_pc_d;
            end
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: vector table, handshake corner sequences and randomized traffic against a byte-level memory model
module tb_mem_access;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  in_regWAddr;
    logic [31:0] in_regRData2, in_result, in_pc;
    logic        mem_read, mem_write, mem_unsigned, flush;
    logic [1:0]  mem_size;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        mem_stall, misalign_err, bus_err;
    logic [4:0]  wb_regWAddr;
    logic [31:0] wb_result, wb_pc;
    int checks = 0;
    int errors = 0;

    mem_access #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .reset(reset), .in_regWAddr(in_regWAddr), .in_regRData2(in_regRData2),
        .in_result(in_result), .in_pc(in_pc), .mem_read(mem_read), .mem_write(mem_write),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .flush(flush),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .misalign_err(misalign_err), .bus_err(bus_err),
        .wb_regWAddr(wb_regWAddr), .wb_result(wb_result), .wb_pc(wb_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd_op;
        logic        wr_op;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        logic        exp_req;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_res;
        logic [4:0]  exp_rd;
        logic        exp_mis;
    } vec_t;

    vec_t       vt [14];
    logic [7:0] mbyte [64];
    logic [31:0] bmem [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd_op, input logic wr_op, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd,
                         input logic [31:0] pc);
        mem_read     = rd_op;
        mem_write    = wr_op;
        mem_size     = size;
        mem_unsigned = uns;
        in_result    = addr;
        in_regRData2 = data;
        in_regWAddr  = rd;
        in_pc        = pc;
        flush        = 1'b0;
    endtask

    task automatic run_random(input int count);
        logic [31:0] a, data, pc, exp_res, v, w, rword;
        logic [4:0]  rd, exp_rd;
        logic [1:0]  size;
        logic        uns, mis, stall, done, pend;
        int kind, nb, nreq, dly, widx, ai;
        pend  = 1'b0;
        dly   = 0;
        rword = 32'd0;
        for (int n = 0; n < count; n++) begin
            kind = $urandom_range(0, 2);
            size = 2'($urandom_range(0, 3));
            uns  = 1'($urandom);
            data = $urandom;
            rd   = 5'($urandom_range(1, 31));
            pc   = $urandom;
            a    = (kind == 0) ? $urandom : 32'($urandom_range(0, 63));
            ai   = int'(a[5:0]);
            nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
            mis  = (kind != 0) && ((ai % nb) != 0);
            exp_rd  = rd;
            exp_res = a;
            if (mis) begin
                exp_rd  = 5'd0;
                exp_res = 32'd0;
            end else if (kind == 2) begin
                exp_rd = 5'd0;
                for (int k = 0; k < nb; k++) mbyte[ai + k] = data[8*k +: 8];
            end else if (kind == 1) begin
                v = 32'd0;
                for (int k = 0; k < nb; k++) v = v | (32'(mbyte[ai + k]) << (8 * k));
                if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
                exp_res = v;
            end
            drive(kind == 1, kind == 2, size, uns, a, data, rd, pc);
            nreq = 0;
            done = 1'b0;
            for (int c = 0; c < 20 && !done; c++) begin
                dmem_rvalid = pend && dly == 0;
                dmem_rdata  = dmem_rvalid ? rword : $urandom;
                #1;
                dmem_gnt = dmem_req && !pend && ($urandom_range(0, 2) != 0);
                #1;
                stall = mem_stall;
                if (dmem_rvalid) pend = 1'b0;
                else if (pend) dly--;
                if (dmem_req && dmem_gnt) begin
                    nreq++;
                    check("rnd_addr", dmem_addr, a & 32'hFFFF_FFFC);
                    widx = int'(dmem_addr[5:2]);
                    w = bmem[widx];
                    for (int b = 0; b < 4; b++) if (dmem_wstrb[b]) w[8*b +: 8] = dmem_wdata[8*b +: 8];
                    bmem[widx] = w;
                    rword = w;
                    pend  = 1'b1;
                    dly   = $urandom_range(0, 2);
                end
                done = !stall;
                tick();
            end
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
            check("rnd_done", 32'(done), 32'd1);
            check("rnd_nreq", 32'(nreq), 32'((kind != 0) && !mis));
            check("rnd_wb_rd", 32'(wb_regWAddr), 32'(exp_rd));
            check("rnd_wb_result", wb_result, exp_res);
            check("rnd_wb_pc", wb_pc, pc);
            check("rnd_misalign", 32'(misalign_err), 32'(mis));
            check("rnd_bus_err", 32'(bus_err), 32'd0);
        end
    endtask

    initial begin
        int nreq;
        logic [31:0] pc;
        vt[0]  = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h1234, 32'h0, 32'h0,        1'b0, 4'h0,    32'h0,        32'h1234,      5'd5, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h103,  32'h0, 32'h80FF0000, 1'b1, 4'h0,    32'h0,        32'hFFFFFF80,  5'd5, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h103,  32'h0, 32'h80FF0000, 1'b1, 4'h0,    32'h0,        32'h80,        5'd5, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h102,  32'h0, 32'h80FF0000, 1'b1, 4'h0,    32'h0,        32'hFFFF80FF,  5'd5, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h100,  32'h0, 32'h12348765, 1'b1, 4'h0,    32'h0,        32'h8765,      5'd5, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h104,  32'h0, 32'hDEADBEEF, 1'b1, 4'h0,    32'h0,        32'hDEADBEEF,  5'd5, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h101,  32'h112233A5, 32'h0, 1'b1, 4'b0010, 32'hA5A5A5A5, 32'h101,       5'd0, 1'b0};
        vt[7]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h102,  32'h0000ABCD, 32'h0, 1'b1, 4'b1100, 32'hABCDABCD, 32'h102,       5'd0, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h108,  32'hCAFEF00D, 32'h0, 1'b1, 4'b1111, 32'hCAFEF00D, 32'h108,       5'd0, 1'b0};
        vt[9]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h101,  32'h0, 32'h0,        1'b0, 4'h0,    32'h0,        32'h0,         5'd0, 1'b1};
        vt[10] = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h103,  32'h1234, 32'h0,     1'b0, 4'h0,    32'h0,        32'h0,         5'd0, 1'b1};
        vt[11] = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h104,  32'h0, 32'h01020304, 1'b1, 4'h0,    32'h0,        32'h01020304,  5'd5, 1'b0};
        vt[12] = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h106,  32'h0, 32'h7FFF0000, 1'b1, 4'h0,    32'h0,        32'h7FFF,      5'd5, 1'b0};
        vt[13] = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h10B,  32'h5A, 32'h0,       1'b1, 4'b1000, 32'h5A5A5A5A, 32'h10B,       5'd0, 1'b0};

        reset = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb_rd", 32'(wb_regWAddr), 32'd0);
        check("rst_wb_result", wb_result, 32'd0);
        check("rst_wb_pc", wb_pc, 32'd0);
        check("rst_misalign", 32'(misalign_err), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            pc = 32'h400 + 32'(i * 4);
            drive(vt[i].rd_op, vt[i].wr_op, vt[i].size, vt[i].uns, vt[i].addr, vt[i].data, 5'd5, pc);
            dmem_gnt = 1'b1;
            #1;
            check("vec_req", 32'(dmem_req), 32'(vt[i].exp_req));
            check("vec_stall", 32'(mem_stall), 32'(vt[i].exp_req));
            if (vt[i].exp_req) begin
                check("vec_strb", 32'(dmem_wstrb), 32'(vt[i].exp_strb));
                check("vec_wdata", dmem_wdata, vt[i].exp_wdata);
                check("vec_addr", dmem_addr, vt[i].addr & 32'hFFFF_FFFC);
                check("vec_we", 32'(dmem_we), 32'(vt[i].wr_op));
            end
            tick();
            dmem_gnt = 1'b0;
            if (vt[i].exp_req) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = vt[i].rdata;
                #1;
                check("vec_stall_resp", 32'(mem_stall), 32'd0);
                tick();
                dmem_rvalid = 1'b0;
            end
            check("vec_wb_result", wb_result, vt[i].exp_res);
            check("vec_wb_rd", 32'(wb_regWAddr), 32'(vt[i].exp_rd));
            check("vec_wb_pc", wb_pc, pc);
            check("vec_misalign", 32'(misalign_err), 32'(vt[i].exp_mis));
            check("vec_bus_err", 32'(bus_err), 32'd0);
            drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
            tick();
            check("vec_misalign_clear", 32'(misalign_err), 32'd0);
        end

        drive(1'b0, 1'b1, 2'd1, 1'b0, 32'h102, 32'h0000ABCD, 5'd6, 32'h600);
        nreq = 0;
        for (int c = 0; c < 4; c++) begin
            dmem_gnt = (c == 3);
            #1;
            if (dmem_req) nreq++;
            check("sh_strb", 32'(dmem_wstrb), 32'b1100);
            check("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
            check("sh_stall", 32'(mem_stall), 32'd1);
            tick();
        end
        dmem_gnt = 1'b0;
        #1;
        check("sh_req_cycles", 32'(nreq), 32'd4);
        check("sh_req_after_gnt", 32'(dmem_req), 32'd0);
        dmem_rvalid = 1'b1;
        #1;
        check("sh_stall_ack", 32'(mem_stall), 32'd0);
        tick();
        dmem_rvalid = 1'b0;
        check("sh_wb_rd", 32'(wb_regWAddr), 32'd0);
        check("sh_wb_result", wb_result, 32'h102);

        drive(1'b0, 1'b0, 2'd2, 1'b0, 32'h77, 32'h0, 5'd7, 32'h700);
        tick();
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd8, 32'h704);
        dmem_gnt = 1'b1;
        #1;
        tick();
        dmem_gnt = 1'b0;
        flush = 1'b1;
        #1;
        check("drain_stall_flush", 32'(mem_stall), 32'd1);
        tick();
        flush = 1'b0;
        #1;
        check("drain_stall_wait", 32'(mem_stall), 32'd1);
        check("drain_wb_hold", wb_result, 32'h77);
        tick();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h55;
        #1;
        check("drain_stall_rvalid", 32'(mem_stall), 32'd1);
        tick();
        dmem_rvalid = 1'b0;
        check("drain_wb_rd", 32'(wb_regWAddr), 32'd0);
        check("drain_wb_result", wb_result, 32'd0);
        check("drain_wb_pc", wb_pc, 32'd0);
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
        #1;
        check("drain_stall_release", 32'(mem_stall), 32'd0);

        drive(1'b0, 1'b0, 2'd2, 1'b0, 32'h77, 32'h0, 5'd7, 32'h710);
        tick();
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd8, 32'h714);
        #1;
        tick();
        flush = 1'b1;
        #1;
        check("gntflush_req", 32'(dmem_req), 32'd1);
        tick();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
        check("gntflush_wb_result", wb_result, 32'd0);
        check("gntflush_wb_pc", wb_pc, 32'd0);
        #1;
        check("gntflush_req_after", 32'(dmem_req), 32'd0);

        drive(1'b0, 1'b0, 2'd2, 1'b0, 32'h99, 32'h0, 5'd9, 32'h900);
        tick();
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd3, 32'h500);
        dmem_gnt = 1'b1;
        #1;
        tick();
        dmem_gnt = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("to_stall", 32'(mem_stall), 32'(c < 3));
            check("to_bus_err_low", 32'(bus_err), 32'd0);
            tick();
        end
        check("to_bus_err", 32'(bus_err), 32'd1);
        check("to_wb_rd", 32'(wb_regWAddr), 32'd0);
        check("to_wb_result", wb_result, 32'd0);
        check("to_wb_pc", wb_pc, 32'h500);
        drive(1'b0, 1'b0, 2'd2, 1'b0, 32'h3C, 32'h0, 5'd1, 32'h3C0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hBAD;
        #1;
        check("stray_req", 32'(dmem_req), 32'd0);
        check("stray_stall", 32'(mem_stall), 32'd0);
        tick();
        dmem_rvalid = 1'b0;
        check("stray_bus_err_pulse", 32'(bus_err), 32'd0);
        check("stray_wb_result", wb_result, 32'h3C);
        check("stray_wb_rd", 32'(wb_regWAddr), 32'd1);

        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd4, 32'h800);
        #1;
        tick();
        #1;
        check("rstmid_req_before", 32'(dmem_req), 32'd1);
        reset = 1'b0;
        #1;
        check("rstmid_req", 32'(dmem_req), 32'd0);
        check("rstmid_wb_rd", 32'(wb_regWAddr), 32'd0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1111;
        tick();
        drive(1'b0, 1'b0, 2'd2, 1'b0, 32'h2E, 32'h0, 5'd2, 32'h2E0);
        reset = 1'b1;
        #1;
        tick();
        dmem_rvalid = 1'b0;
        check("rstmid_wb_result", wb_result, 32'h2E);
        check("rstmid_wb_rd_after", 32'(wb_regWAddr), 32'd2);
        check("rstmid_bus_err", 32'(bus_err), 32'd0);

        for (int i = 0; i < 64; i++) mbyte[i] = 8'($urandom);
        for (int w = 0; w < 16; w++) bmem[w] = {mbyte[4*w+3], mbyte[4*w+2], mbyte[4*w+1], mbyte[4*w]};
        run_random(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
